y86_prog_loader: RTL

Stimulus-side counterpart to the pipelined-core observation harness. It accepts a framed byte stream over a valid/ready handshake and writes the payload into the Y86-64 instruction/data memory. It holds the pipeline core in reset while loading and releases it with a start PC once the frame checksum passes. When the core reports halt, the loader returns to idle so another program can be loaded without a global reset.

---
 rtl/y86_prog_loader_if.sv | 34 +++
 rtl/y86_prog_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/y86_prog_loader_if.sv
// Y86-64 program loader bus bundle: byte stream in, memory write port out,
// and the core-control/status signals.
// Ports: in_valid/in_data/in_ready (stream), mem_we/mem_addr/mem_wdata
// (memory write), cpu_rst_n/start_pc/cpu_halt (core control),
// err_clr/load_done/load_err (status).
// Modport slave is the loader; modport master is the stream source / core side.
interface y86_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst_n;
  logic [63:0]       start_pc;
  logic              cpu_halt;
  logic              err_clr;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  in_valid, in_data, cpu_halt, err_clr,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, start_pc,
           load_done, load_err
  );

  modport master (
    output in_valid, in_data, cpu_halt, err_clr,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, start_pc,
           load_done, load_err
  );
endinterface

// File: rtl/y86_prog_loader.sv
// Loads a framed byte stream into Y86-64 memory, then releases the core.
// Latency: each payload byte is written one cycle after its accepting edge.
// Backpressure: in_ready is low only while the core runs or a frame error is pending.
// Ports: clk, rst_n (async active-low), bus (slave side of y86_prog_loader_if).
// Frame: ADDR_LO ADDR_HI LEN_LO LEN_HI payload[LEN] CSUM, where CSUM is the
// 8-bit sum of every preceding frame byte.
module y86_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input logic              clk,
  input logic              rst_n,
  y86_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  localparam logic [16:0] MEM_LIM = 17'(MEM_BYTES);

  state_t            state, state_nxt;
  logic [15:0]       addr, addr_nxt;
  logic [15:0]       len, len_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [7:0]        sum, sum_nxt;
  logic              in_ready, in_ready_nxt;
  logic              mem_we, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr, mem_addr_nxt;
  logic [7:0]        mem_wdata, mem_wdata_nxt;
  logic              cpu_rst_n, cpu_rst_n_nxt;
  logic [63:0]       start_pc, start_pc_nxt;
  logic              load_done, load_done_nxt;
  logic              load_err, load_err_nxt;

  logic              xfer;
  logic [15:0]       len_full;
  logic [16:0]       end_addr;

  assign xfer     = bus.in_valid && in_ready;
  // Full length as it will be once the LEN_HI byte lands; 17-bit end so that
  // a large header cannot wrap back into range.
  assign len_full = {bus.in_data, len[7:0]};
  assign end_addr = {1'b0, addr} + {1'b0, len_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ADDR_LO;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      start_pc  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      len       <= len_nxt;
      cnt       <= cnt_nxt;
      sum       <= sum_nxt;
      in_ready  <= in_ready_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rst_n <= cpu_rst_n_nxt;
      start_pc  <= start_pc_nxt;
      load_done <= load_done_nxt;
      load_err  <= load_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    len_nxt       = len;
    cnt_nxt       = cnt;
    sum_nxt       = sum;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_rst_n_nxt = cpu_rst_n;
    start_pc_nxt  = start_pc;
    load_done_nxt = load_done;
    load_err_nxt  = load_err;

    case (state)
      S_ADDR_LO: if (xfer) begin
        addr_nxt[7:0] = bus.in_data;
        sum_nxt       = sum + bus.in_data;
        state_nxt     = S_ADDR_HI;
      end
      S_ADDR_HI: if (xfer) begin
        addr_nxt[15:8] = bus.in_data;
        sum_nxt        = sum + bus.in_data;
        state_nxt      = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_nxt[7:0] = bus.in_data;
        sum_nxt      = sum + bus.in_data;
        state_nxt    = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) begin
        len_nxt = len_full;
        cnt_nxt = '0;
        sum_nxt = sum + bus.in_data;
        // Out-of-range base is rejected even for an empty payload.
        if (({1'b0, addr} >= MEM_LIM) || (end_addr > MEM_LIM)) begin
          state_nxt    = S_ERR;
          load_err_nxt = 1'b1;
        end else if (len_full == 16'd0) begin
          state_nxt = S_CSUM;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: if (xfer) begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = addr[ADDR_W-1:0] + cnt[ADDR_W-1:0];
        mem_wdata_nxt = bus.in_data;
        sum_nxt       = sum + bus.in_data;
        cnt_nxt       = cnt + 16'd1;
        if (cnt == len - 16'd1) state_nxt = S_CSUM;
      end
      S_CSUM: if (xfer) begin
        if (bus.in_data == sum) begin
          state_nxt     = S_RUN;
          cpu_rst_n_nxt = 1'b1;
          load_done_nxt = 1'b1;
          start_pc_nxt  = {48'd0, addr};
        end else begin
          state_nxt    = S_ERR;
          load_err_nxt = 1'b1;
        end
      end
      S_RUN: if (bus.cpu_halt) begin
        state_nxt     = S_ADDR_LO;
        cpu_rst_n_nxt = 1'b0;
        load_done_nxt = 1'b0;
        sum_nxt       = '0;
        cnt_nxt       = '0;
      end
      S_ERR: if (bus.err_clr) begin
        state_nxt    = S_ADDR_LO;
        load_err_nxt = 1'b0;
        sum_nxt      = '0;
      end
      default: state_nxt = S_ADDR_LO;
    endcase

    // Registered so that in_ready drops on the same edge that enters RUN/ERR.
    in_ready_nxt = (state_nxt != S_RUN) && (state_nxt != S_ERR);
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_rst_n = cpu_rst_n;
  assign bus.start_pc  = start_pc;
  assign bus.load_done = load_done;
  assign bus.load_err  = load_err;

endmodule
